// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between the
// instruction-fetch port and the load/store port, tracking one outstanding read.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_mask,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                m_en,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_mask,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata,

    output logic                busy
);

    localparam int MASK_W = DATA_W / 8;

    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
        $error("mem_arbiter: MEM_LAT must be in 1..4");
    end

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [2:0]          lat_cnt_q, lat_cnt_d;
    logic                rr_q, rr_d;          // 1 = D favoured on a tie
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;

    logic                return_cycle;
    logic                eligible;
    logic                i_win;
    logic                d_win;
    logic                read_grant;

    // Read data is a straight wire; rvalid qualifies it.
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;
    assign busy    = (state_q == ST_WAIT);

    // NOTE: every signal written below gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lat_cnt_d = lat_cnt_q;
        rr_d      = rr_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;

        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        m_en      = 1'b0;
        m_we      = 1'b0;
        m_mask    = '0;
        m_addr    = m_addr_q;
        m_wdata   = m_wdata_q;

        return_cycle = (state_q == ST_WAIT) && (lat_cnt_q == 3'd1);
        // Gating with rst_n keeps the combinational grant path quiet while in reset.
        eligible     = rst_n && ((state_q == ST_IDLE) || return_cycle);
        i_win        = eligible && i_req && (!d_req || !rr_q);
        d_win        = eligible && d_req && (!i_req ||  rr_q);
        read_grant   = i_win || (d_win && !d_we);

        if (return_cycle) begin
            i_rvalid = (owner_q == OWN_I);
            d_rvalid = (owner_q == OWN_D);
        end

        if (i_win) begin
            i_gnt    = 1'b1;
            m_en     = 1'b1;
            m_mask   = {MASK_W{1'b1}};
            m_addr   = i_addr;
            m_addr_d = i_addr;
            rr_d     = 1'b1;
        end else if (d_win) begin
            d_gnt     = 1'b1;
            m_en      = 1'b1;
            m_we      = d_we;
            m_mask    = d_we ? d_mask : {MASK_W{1'b1}};
            m_addr    = d_addr;
            m_wdata   = d_wdata;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            rr_d      = 1'b0;
        end

        if (read_grant) begin
            state_d   = ST_WAIT;
            owner_d   = i_win ? OWN_I : OWN_D;
            lat_cnt_d = 3'(MEM_LAT);
        end else if (state_q == ST_WAIT) begin
            if (return_cycle) begin
                state_d   = ST_IDLE;
                lat_cnt_d = 3'd0;
            end else begin
                lat_cnt_d = lat_cnt_q - 3'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its peers, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_I;
            lat_cnt_q <= 3'd0;
            rr_q      <= 1'b1;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            lat_cnt_q <= lat_cnt_d;
            rr_q      <= rr_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (MEM_LAT 1..3) share stimulus,
// each scenario checks the instance whose latency it targets.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_mask;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] m_rdata;

    logic        i_gnt_w    [1:3];
    logic        i_rvalid_w [1:3];
    logic [31:0] i_rdata_w  [1:3];
    logic        d_gnt_w    [1:3];
    logic        d_rvalid_w [1:3];
    logic [31:0] d_rdata_w  [1:3];
    logic        m_en_w     [1:3];
    logic        m_we_w     [1:3];
    logic [3:0]  m_mask_w   [1:3];
    logic [31:0] m_addr_w   [1:3];
    logic [31:0] m_wdata_w  [1:3];
    logic        busy_w     [1:3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 1; g <= 3; g++) begin : g_dut
        mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_req    (i_req),
            .i_addr   (i_addr),
            .i_gnt    (i_gnt_w[g]),
            .i_rvalid (i_rvalid_w[g]),
            .i_rdata  (i_rdata_w[g]),
            .d_req    (d_req),
            .d_we     (d_we),
            .d_mask   (d_mask),
            .d_addr   (d_addr),
            .d_wdata  (d_wdata),
            .d_gnt    (d_gnt_w[g]),
            .d_rvalid (d_rvalid_w[g]),
            .d_rdata  (d_rdata_w[g]),
            .m_en     (m_en_w[g]),
            .m_we     (m_we_w[g]),
            .m_mask   (m_mask_w[g]),
            .m_addr   (m_addr_w[g]),
            .m_wdata  (m_wdata_w[g]),
            .m_rdata  (m_rdata),
            .busy     (busy_w[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Move to just after the next rising edge; inputs change here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling, well clear of the edge.
    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_mask  = '0;
        d_addr  = '0;
        d_wdata = '0;
        m_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Expected per-cycle grant/valid pattern for both ports held, MEM_LAT=1.
    logic [3:0]  sim_exp [0:4];   // {d_gnt, i_gnt, d_rvalid, i_rvalid}
    logic [31:0] sim_addr[0:3];

    initial begin
        sim_exp[0] = 4'b1000; sim_addr[0] = 32'h200;
        sim_exp[1] = 4'b0110; sim_addr[1] = 32'h100;
        sim_exp[2] = 4'b1001; sim_addr[2] = 32'h200;
        sim_exp[3] = 4'b0110; sim_addr[3] = 32'h100;
        sim_exp[4] = 4'b0001;

        // Reset state, with both requests asserted to show grants are suppressed.
        idle_inputs();
        rst_n = 1'b0;
        i_req = 1'b1;
        d_req = 1'b1;
        d_we  = 1'b1;
        d_mask = 4'hF;
        d_addr = 32'h55;
        d_wdata = 32'h66;
        #3;
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("rst_gnt_%0d", k), {i_gnt_w[k], d_gnt_w[k]}, 2'b00);
            check($sformatf("rst_rvalid_%0d", k), {i_rvalid_w[k], d_rvalid_w[k]}, 2'b00);
            check($sformatf("rst_men_we_busy_%0d", k), {m_en_w[k], m_we_w[k], busy_w[k]}, 3'b000);
            check($sformatf("rst_mask_%0d", k), m_mask_w[k], 4'h0);
            check($sformatf("rst_addr_%0d", k), m_addr_w[k], 32'h0);
            check($sformatf("rst_wdata_%0d", k), m_wdata_w[k], 32'h0);
        end
        step();
        step();
        idle_inputs();
        rst_n = 1'b1;

        // Single fetch, MEM_LAT=1.
        do_reset();
        i_req  = 1'b1;
        i_addr = 32'h10;
        settle();
        check("fetch_gnt", i_gnt_w[1], 1'b1);
        check("fetch_men", m_en_w[1], 1'b1);
        check("fetch_addr", m_addr_w[1], 32'h10);
        check("fetch_we", m_we_w[1], 1'b0);
        check("fetch_mask", m_mask_w[1], 4'hF);
        check("fetch_busy0", busy_w[1], 1'b0);
        check("fetch_rvalid0", i_rvalid_w[1], 1'b0);
        step();
        i_req   = 1'b0;
        m_rdata = 32'h1234_5678;
        settle();
        check("fetch_rvalid1", i_rvalid_w[1], 1'b1);
        check("fetch_rdata1", i_rdata_w[1], 32'h1234_5678);
        check("fetch_busy1", busy_w[1], 1'b1);
        check("fetch_drvalid1", d_rvalid_w[1], 1'b0);
        check("fetch_men1", m_en_w[1], 1'b0);
        step();
        settle();
        check("fetch_busy2", busy_w[1], 1'b0);
        check("fetch_rvalid2", i_rvalid_w[1], 1'b0);

        // Both requesters held after reset: d, i, d, i with matching returns.
        do_reset();
        i_req  = 1'b1;
        i_addr = 32'h100;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h200;
        for (int c = 0; c <= 4; c++) begin
            if (c == 4) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
            m_rdata = 32'hA000_0000 + 32'(c);
            settle();
            check($sformatf("rr_c%0d", c),
                  {d_gnt_w[1], i_gnt_w[1], d_rvalid_w[1], i_rvalid_w[1]}, sim_exp[c]);
            if (c < 4) check($sformatf("rr_addr_c%0d", c), m_addr_w[1], sim_addr[c]);
            if (sim_exp[c][1]) check($sformatf("rr_drdata_c%0d", c), d_rdata_w[1], 32'hA000_0000 + 32'(c));
            if (sim_exp[c][0]) check($sformatf("rr_irdata_c%0d", c), i_rdata_w[1], 32'hA000_0000 + 32'(c));
            step();
        end

        // Store pass-through, then a zero-mask store.
        do_reset();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_mask  = 4'b0011;
        d_addr  = 32'h20;
        d_wdata = 32'hAABB_CCDD;
        settle();
        check("st_gnt", d_gnt_w[1], 1'b1);
        check("st_men_we", {m_en_w[1], m_we_w[1]}, 2'b11);
        check("st_mask", m_mask_w[1], 4'b0011);
        check("st_addr", m_addr_w[1], 32'h20);
        check("st_wdata", m_wdata_w[1], 32'hAABB_CCDD);
        check("st_busy0", busy_w[1], 1'b0);
        step();
        d_req = 1'b0;
        settle();
        check("st_rvalid", d_rvalid_w[1], 1'b0);
        check("st_busy1", busy_w[1], 1'b0);
        check("st_idle_bus", {m_en_w[1], m_we_w[1], m_mask_w[1]}, 6'b000000);
        check("st_hold_addr", m_addr_w[1], 32'h20);
        check("st_hold_wdata", m_wdata_w[1], 32'hAABB_CCDD);
        step();
        d_req   = 1'b1;
        d_mask  = 4'b0000;
        d_addr  = 32'h24;
        settle();
        check("st0_gnt_we", {d_gnt_w[1], m_we_w[1]}, 2'b11);
        check("st0_mask", m_mask_w[1], 4'h0);
        step();
        d_req = 1'b0;
        settle();
        check("st0_busy", busy_w[1], 1'b0);

        // MEM_LAT=3: load granted at T holds off a pending fetch until T+3.
        do_reset();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h40;
        i_req  = 1'b1;
        i_addr = 32'h44;
        settle();
        check("l3_T_gnt", {d_gnt_w[3], i_gnt_w[3]}, 2'b10);
        check("l3_T_mask", m_mask_w[3], 4'hF);
        step();
        d_req = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            settle();
            check($sformatf("l3_T%0d_hold", c), {i_gnt_w[3], m_en_w[3], d_rvalid_w[3]}, 3'b000);
            check($sformatf("l3_T%0d_busy", c), busy_w[3], 1'b1);
            step();
        end
        m_rdata = 32'hCAFE_F00D;
        settle();
        check("l3_T3_drvalid", d_rvalid_w[3], 1'b1);
        check("l3_T3_drdata", d_rdata_w[3], 32'hCAFE_F00D);
        check("l3_T3_igrant", i_gnt_w[3], 1'b1);
        check("l3_T3_addr", m_addr_w[3], 32'h44);
        step();
        i_req = 1'b0;
        settle();
        check("l3_T4_busy", busy_w[3], 1'b1);
        check("l3_T4_valid", {d_rvalid_w[3], i_rvalid_w[3]}, 2'b00);

        // MEM_LAT=2: reset pulse during WAIT discards the outstanding read.
        do_reset();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h80;
        settle();
        check("rw_gnt", d_gnt_w[2], 1'b1);
        step();
        d_req = 1'b0;
        rst_n = 1'b0;
        settle();
        check("rw_in_rst", {busy_w[2], d_rvalid_w[2], d_gnt_w[2], m_en_w[2], m_we_w[2]}, 5'b0);
        check("rw_in_rst_addr", m_addr_w[2], 32'h0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            check($sformatf("rw_after_%0d", c), {d_rvalid_w[2], busy_w[2]}, 2'b00);
            step();
        end

        // MEM_LAT=3: fetch request withdrawn while blocked never shows up.
        do_reset();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h90;
        settle();
        check("wd_dgnt", d_gnt_w[3], 1'b1);
        step();
        d_req  = 1'b0;
        i_req  = 1'b1;
        i_addr = 32'h94;
        settle();
        check("wd_T1", {i_gnt_w[3], m_en_w[3]}, 2'b00);
        step();
        i_req = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            settle();
            check($sformatf("wd_T%0d", c), {i_gnt_w[3], m_en_w[3]}, 2'b00);
            if (c == 3) check("wd_T3_drvalid", d_rvalid_w[3], 1'b1);
            if (c == 4) check("wd_T4_busy", busy_w[3], 1'b0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
